vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator that replaces the fixed 640x480 generator. It sits between the pixel-strobe divider and the framebuffer/pixel pipeline. It produces sync, data-enable, coordinate and frame-event outputs for any mode defined by per-axis porch/sync parameters. Compared with the fixed generator it adds:
- sync polarity selection
- a frame counter
- single-cycle event pulses
- a clean start/stop handshake that only starts or stops at a frame boundary

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of o_hs
- VS_POL, 0, asserted level of o_vs
- X_W, 10, width of o_x and of the horizontal counter; must hold H_TOTAL-1
- Y_W, 10, width of o_y and of the vertical counter; must hold V_TOTAL-1
- FRAME_W, 16, width of o_frame

Ports:
- i_clk  in  1  system clock; the only clock
- i_rst_n  in  1  synchronous, active-low reset
- i_pix_stb  in  1  pixel strobe, one i_clk cycle wide; the raster advances only on cycles where this is high
- i_en  in  1  run request; sampled only on strobe cycles
- o_hs  out  1  horizontal sync, registered
- o_vs  out  1  vertical sync, registered
- o_de  out  1  high while the current pixel is inside the active area
- o_blanking  out  1  equals ~o_de
- o_x  out  X_W  horizontal pixel coordinate
- o_y  out  Y_W  vertical pixel coordinate
- o_line_end  out  1  one-cycle pulse at the end of each line
- o_animate  out  1  one-cycle pulse at the end of the last active pixel of a frame
- o_frame_end  out  1  one-cycle pulse at the end of each frame
- o_frame  out  FRAME_W  count of completed frames; wraps at 2^FRAME_W
- o_running  out  1  high while the FSM is in RUN

## Operation
Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.

Counters h and v start at 0. The active area comes first on each axis, so pixel (0,0) is the first visible pixel.

FSM has two states, IDLE and RUN.
- IDLE:
  - h=0, v=0.
  - Outputs are masked: o_de=0, o_hs=~HS_POL, o_vs=~VS_POL, o_x=0, o_y=0.
  - A strobe cycle with i_en=1 moves the FSM to RUN. The counters stay at (0,0), so pixel (0,0) is presented for one full strobe period.
- RUN: on each strobe, h increments.
  - When h=H_TOTAL-1, h wraps to 0 and v increments.
  - When additionally v=V_TOTAL-1, v wraps to 0 and o_frame increments. If i_en=0 on that same strobe, the FSM returns to IDLE.
  - Deasserting i_en in mid-frame has no effect until the frame completes.

Sync and enable decode:
- hsync is asserted when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. o_hs = HS_POL when asserted, ~HS_POL otherwise. Vertical decode is identical, using v and the V_* parameters.
- o_de = (h<H_ACTIVE) && (v<V_ACTIVE) && RUN.

Coordinates:
- o_x = h when h<H_ACTIVE, otherwise H_ACTIVE-1 (clamped).
- o_y = v when v<V_ACTIVE, otherwise V_ACTIVE-1.

Pulses: each pulse is high for exactly one i_clk cycle, namely the cycle after the qualifying strobe, and only in RUN.
- o_line_end qualifies at h=H_TOTAL-1.
- o_animate qualifies at h=H_ACTIVE-1, v=V_ACTIVE-1.
- o_frame_end qualifies at h=H_TOTAL-1, v=V_TOTAL-1.

Coincident events: o_line_end and o_frame_end assert together on the last pixel of a frame.

## Timing
Reset (i_rst_n=0 at a clock edge) takes priority over every other input. Values after the reset edge:
- state=IDLE, h=0, v=0, o_frame=0
- o_hs=~HS_POL, o_vs=~VS_POL
- o_de=0, o_blanking=1, o_x=0, o_y=0
- all pulses 0, o_running=0

Reset asserted mid-frame aborts the frame immediately, with no drain.

Latency: every output is registered. Outputs reflect the new (h,v,state) in the cycle immediately after the strobe edge that produced them.

Between strobes all outputs hold, apart from pulses dropping after one cycle.

i_pix_stb held high continuously is legal and advances the raster one pixel per clock.

## Structure
Package vga_timing_pkg holds:
- the state enum {IDLE, RUN}
- 640x480@60 default constants
- an 800x600@72 constant set

One sub-module, vga_axis_counter, is instantiated twice (h and v). It provides parametrised ACTIVE/FP/SYNC/BP, increment-enable, wrap flag, sync-asserted and in-active outputs.

The top level holds the FSM, coordinate clamping, pulse registers and the frame counter.

## Test plan
All scenarios use small parameters: H 8/2/2/4 (H_TOTAL=16) and V 4/1/1/2 (V_TOTAL=8), HS_POL=0, VS_POL=1, with a strobe every 2nd clock.
- Reset, then i_en=1 on the first strobe -> o_running=1, o_de=1, o_x=0, o_y=0; before that strobe, o_hs=1 and o_vs=0.
- Run one line -> o_hs=0 exactly while h is 10..11; o_de=0 for h 8..15 with o_x clamped at 7; o_line_end pulses once after h=15; o_y becomes 1.
- Run a full frame of 128 strobes -> o_vs=1 only on v=5; o_animate pulses after pixel (7,3); o_line_end and o_frame_end pulse together after (15,7); o_frame=1.
- Drop i_en at pixel (3,2) -> generation continues to (15,7), then IDLE with outputs masked and o_frame incremented. Raising i_en then restarts at (0,0).
- Assert i_rst_n=0 at pixel (5,6) -> all outputs take their reset values on the next edge and o_frame=0.
- Set FRAME_W=2 and run 4 frames -> o_frame follows 1, 2, 3, 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared state type and standard mode constants for the VGA raster timing generator.
package vga_timing_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
  localparam int   VGA640_H_ACTIVE = 640;
  localparam int   VGA640_H_FP     = 16;
  localparam int   VGA640_H_SYNC   = 96;
  localparam int   VGA640_H_BP     = 48;
  localparam int   VGA640_V_ACTIVE = 480;
  localparam int   VGA640_V_FP     = 10;
  localparam int   VGA640_V_SYNC   = 2;
  localparam int   VGA640_V_BP     = 33;
  localparam logic VGA640_HS_POL   = 1'b0;
  localparam logic VGA640_VS_POL   = 1'b0;

  // 800x600 @ 72 Hz, 50 MHz pixel clock, positive syncs
  localparam int   SVGA800_H_ACTIVE = 800;
  localparam int   SVGA800_H_FP     = 56;
  localparam int   SVGA800_H_SYNC   = 120;
  localparam int   SVGA800_H_BP     = 64;
  localparam int   SVGA800_V_ACTIVE = 600;
  localparam int   SVGA800_V_FP     = 37;
  localparam int   SVGA800_V_SYNC   = 6;
  localparam int   SVGA800_V_BP     = 23;
  localparam logic SVGA800_HS_POL   = 1'b1;
  localparam logic SVGA800_VS_POL   = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus decode of its next value,
// so the parent can register outputs that line up with the updated count.
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o,
  output logic [W-1:0] nxt_o,
  output logic         nxt_sync_o,
  output logic         nxt_active_o
);

  localparam int           TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  // One extra bit so the sync end bound can equal 2^W without wrapping
  localparam logic [W:0]   SYNC_BEG = (W+1)'(ACTIVE + FP);
  localparam logic [W:0]   SYNC_END = (W+1)'(ACTIVE + FP + SYNC);
  localparam logic [W:0]   ACT_END  = (W+1)'(ACTIVE);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign last_o       = (cnt_q == LAST);
  assign nxt_o        = cnt_d;
  assign nxt_sync_o   = ({1'b0, cnt_d} >= SYNC_BEG) && ({1'b0, cnt_d} < SYNC_END);
  assign nxt_active_o = ({1'b0, cnt_d} < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: run/idle FSM that starts and stops only on
// frame boundaries, registered sync/DE/coordinate outputs, event pulses, frame count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BP     = VGA640_H_BP,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FP     = VGA640_V_FP,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BP     = VGA640_V_BP,
  parameter logic HS_POL   = VGA640_HS_POL,
  parameter logic VS_POL   = VGA640_VS_POL,
  parameter int   X_W      = 10,
  parameter int   Y_W      = 10,
  parameter int   FRAME_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_stb,
  input  logic               i_en,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic               o_blanking,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic               o_line_end,
  output logic               o_animate,
  output logic               o_frame_end,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_running
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  state_e             state_q, state_d;
  logic               h_inc, v_inc, h_last, v_last, run_d;
  logic [X_W-1:0]     h_cnt, h_nxt;
  logic [Y_W-1:0]     v_cnt, v_nxt;
  logic               h_sync_n, v_sync_n, h_act_n, v_act_n;
  logic               hs_q, vs_q, de_q, line_end_q, animate_q, frame_end_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [FRAME_W-1:0] frame_q;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(X_W)
  ) u_h (
    .clk_i(i_clk), .rst_ni(i_rst_n), .inc_i(h_inc),
    .cnt_o(h_cnt), .last_o(h_last), .nxt_o(h_nxt),
    .nxt_sync_o(h_sync_n), .nxt_active_o(h_act_n)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(Y_W)
  ) u_v (
    .clk_i(i_clk), .rst_ni(i_rst_n), .inc_i(v_inc),
    .cnt_o(v_cnt), .last_o(v_last), .nxt_o(v_nxt),
    .nxt_sync_o(v_sync_n), .nxt_active_o(v_act_n)
  );

  // Counters only move in RUN; leaving RUN coincides with both axes wrapping to 0
  always_comb begin
    state_d = state_q;
    h_inc   = 1'b0;
    v_inc   = 1'b0;
    if (i_pix_stb) begin
      case (state_q)
        IDLE: if (i_en) state_d = RUN;
        RUN: begin
          h_inc = 1'b1;
          v_inc = h_last;
          if (h_last && v_last && !i_en) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign run_d = (state_d == RUN);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      de_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      line_end_q  <= 1'b0;
      animate_q   <= 1'b0;
      frame_end_q <= 1'b0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      hs_q        <= (run_d && h_sync_n) ? HS_POL : ~HS_POL;
      vs_q        <= (run_d && v_sync_n) ? VS_POL : ~VS_POL;
      de_q        <= run_d && h_act_n && v_act_n;
      x_q         <= !run_d ? '0 : (h_act_n ? h_nxt : X_LAST);
      y_q         <= !run_d ? '0 : (v_act_n ? v_nxt : Y_LAST);
      line_end_q  <= v_inc;
      animate_q   <= h_inc && (h_cnt == X_LAST) && (v_cnt == Y_LAST);
      frame_end_q <= v_inc && v_last;
      if (v_inc && v_last) frame_q <= frame_q + 1'b1;
    end
  end

  assign o_hs        = hs_q;
  assign o_vs        = vs_q;
  assign o_de        = de_q;
  assign o_blanking  = ~de_q;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_line_end  = line_end_q;
  assign o_animate   = animate_q;
  assign o_frame_end = frame_end_q;
  assign o_frame     = frame_q;
  assign o_running   = (state_q == RUN);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a small 16x8 raster: hand-derived vector table
// plus random strobe/enable/reset traffic against a linear-pixel-index model.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 4;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst_n, stb, en;
  logic          hs, vs, de, blank, le, an, fe, running;
  logic [9:0]    x, y;
  logic [FW-1:0] frame;

  int checks = 0;
  int errors = 0;

  // Model state: run flag, linear pixel index within the frame, frame count, pulses
  bit m_run;
  int m_p, m_frame;
  bit m_le, m_an, m_fe;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b1), .X_W(10), .Y_W(10), .FRAME_W(FW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .i_en(en),
    .o_hs(hs), .o_vs(vs), .o_de(de), .o_blanking(blank),
    .o_x(x), .o_y(y), .o_line_end(le), .o_animate(an), .o_frame_end(fe),
    .o_frame(frame), .o_running(running)
  );

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  task automatic model_update(input bit s, input bit e, input bit r);
    int h, v;
    m_le = 0; m_an = 0; m_fe = 0;
    if (!r) begin
      m_run = 0; m_p = 0; m_frame = 0;
    end else if (s) begin
      if (!m_run) begin
        if (e) m_run = 1;
      end else begin
        h = m_p % HT;
        v = m_p / HT;
        m_le = (h == HT - 1);
        m_an = (h == HA - 1) && (v == VA - 1);
        m_p++;
        if (m_p == HT * VT) begin
          m_p = 0;
          m_fe = 1;
          m_frame = (m_frame + 1) % (1 << FW);
          if (!e) m_run = 0;
        end
      end
    end
  endtask

  task automatic model_compare();
    int h, v;
    h = m_p % HT;
    v = m_p / HT;
    check("model.running", int'(running), int'(m_run));
    check("model.de", int'(de), int'(m_run && h < HA && v < VA));
    check("model.blank", int'(blank), int'(!(m_run && h < HA && v < VA)));
    check("model.hs", int'(hs), (m_run && h >= HA + HF && h < HA + HF + HSW) ? 0 : 1);
    check("model.vs", int'(vs), (m_run && v >= VA + VF && v < VA + VF + VSW) ? 1 : 0);
    check("model.x", int'(x), m_run ? ((h < HA) ? h : HA - 1) : 0);
    check("model.y", int'(y), m_run ? ((v < VA) ? v : VA - 1) : 0);
    check("model.line_end", int'(le), int'(m_le));
    check("model.animate", int'(an), int'(m_an));
    check("model.frame_end", int'(fe), int'(m_fe));
    check("model.frame", int'(frame), m_frame);
  endtask

  task automatic tick(input bit s, input bit e, input bit r);
    stb = s; en = e; rst_n = r;
    @(posedge clk);
    model_update(s, e, r);
    #1;
    model_compare();
  endtask

  typedef struct {
    int n; bit en; bit rst_n;
    int x, y, de, hs, vs, le, an, fe, frame, run;
  } row_t;

  row_t tbl[$];

  initial begin
    stb = 1'b0; en = 1'b0; rst_n = 1'b0;
    m_run = 0; m_p = 0; m_frame = 0; m_le = 0; m_an = 0; m_fe = 0;

    //           n   en rst  x  y de hs vs le an fe fr run
    tbl.push_back('{1,   1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{8,   1, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{2,   1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1,   1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1,   1, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{4,   1, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{40,  1, 1, 7, 3, 0, 1, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{24,  1, 1, 0, 3, 0, 1, 1, 1, 0, 0, 0, 1});
    tbl.push_back('{16,  1, 1, 0, 3, 0, 1, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{32,  1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1});
    tbl.push_back('{35,  1, 1, 3, 2, 1, 1, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{1,   0, 1, 4, 2, 1, 1, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{92,  0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 2, 0});
    tbl.push_back('{1,   0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0});
    tbl.push_back('{1,   1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2, 1});
    tbl.push_back('{101, 1, 1, 5, 3, 0, 1, 0, 0, 0, 0, 2, 1});
    tbl.push_back('{1,   1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1,   1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{128, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1});
    tbl.push_back('{128, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 2, 1});
    tbl.push_back('{128, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 3, 1});
    tbl.push_back('{128, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1});

    // Reset values, then one idle gap cycle before the first strobe
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("rst.hs", int'(hs), 1);
    check("rst.vs", int'(vs), 0);
    check("rst.de", int'(de), 0);
    check("rst.blank", int'(blank), 1);
    check("rst.x", int'(x), 0);
    check("rst.y", int'(y), 0);
    check("rst.frame", int'(frame), 0);
    check("rst.running", int'(running), 0);
    check("rst.pulses", int'({le, an, fe}), 0);
    tick(1'b0, 1'b1, 1'b1);
    check("pre.hs", int'(hs), 1);
    check("pre.vs", int'(vs), 0);
    check("pre.running", int'(running), 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        tick(1'b1, tbl[i].en, (k == tbl[i].n - 1) ? tbl[i].rst_n : 1'b1);
        if (k < tbl[i].n - 1) tick(1'b0, tbl[i].en, 1'b1);
      end
      check($sformatf("row%0d.x", i), int'(x), tbl[i].x);
      check($sformatf("row%0d.y", i), int'(y), tbl[i].y);
      check($sformatf("row%0d.de", i), int'(de), tbl[i].de);
      check($sformatf("row%0d.blank", i), int'(blank), 1 - tbl[i].de);
      check($sformatf("row%0d.hs", i), int'(hs), tbl[i].hs);
      check($sformatf("row%0d.vs", i), int'(vs), tbl[i].vs);
      check($sformatf("row%0d.line_end", i), int'(le), tbl[i].le);
      check($sformatf("row%0d.animate", i), int'(an), tbl[i].an);
      check($sformatf("row%0d.frame_end", i), int'(fe), tbl[i].fe);
      check($sformatf("row%0d.frame", i), int'(frame), tbl[i].frame);
      check($sformatf("row%0d.running", i), int'(running), tbl[i].run);
      tick(1'b0, tbl[i].en, 1'b1);
      check($sformatf("row%0d.pulse_drop", i), int'({le, an, fe}), 0);
    end

    // Continuous strobe: one pixel per clock
    for (int k = 0; k < 40; k++) tick(1'b1, 1'b1, 1'b1);

    // Random strobes, enables and occasional resets
    for (int k = 0; k < 6000; k++) begin
      tick(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 999) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
